// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution path.
//   - condition-code encodings (COND_NE .. COND_UN)
//   - bit positions of Z/V/N inside the registered flag vector
//   - halt state machine encoding
package branch_pkg;

  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_OV = 3'b110;
  localparam logic [2:0] COND_UN = 3'b111;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 2;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator.
// Ports:
//   flags     in  3  registered flags {N, V, Z}
//   cond      in  3  condition code
//   cond_true out 1  condition holds for the given flags
module cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] cond,
  output logic       cond_true
);

  logic z, v, n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      COND_NE: cond_true = !z;
      COND_EQ: cond_true = z;
      COND_GT: cond_true = !z && !n;
      COND_LT: cond_true = n;
      COND_GE: cond_true = z || (!z && !n);
      COND_LE: cond_true = n || z;
      COND_OV: cond_true = v;
      COND_UN: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_control.sv
// Program counter, branch resolution, halt state machine and taken-branch
// counter for the single-cycle processor.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   flags        registered flags {N, V, Z}
//   br_en        current instruction is B (PC-relative)
//   br_reg       current instruction is BR (register target)
//   cond         branch condition code
//   imm          signed halfword offset for B
//   reg_target   target address for BR (bit0 ignored)
//   halt         current instruction is HLT
//   stall        freeze PC, state and counter this cycle
//   pc           current fetch address
//   pc_plus2     pc + 2 (combinational)
//   taken        current branch is taken (combinational)
//   halted       high while in the HALTED state
//   taken_cnt    saturating count of committed taken branches
module branch_control
  import branch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      IMM_W    = 9,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       flags,
  input  logic             br_en,
  input  logic             br_reg,
  input  logic [2:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             halt,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus2,
  output logic             taken,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             cond_true;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] b_target;
  logic [WIDTH-1:0] br_target;

  cond_eval u_cond_eval (
    .flags     (flags),
    .cond      (cond),
    .cond_true (cond_true)
  );

  assign pc_plus2  = pc + WIDTH'(2);
  assign taken     = (br_en || br_reg) && cond_true && (state_q == ST_RUN);
  assign imm_ext   = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  // Offset is in halfwords; shifting the sign-extended value keeps the sign.
  assign b_target  = pc_plus2 + {imm_ext[WIDTH-2:0], 1'b0};
  assign br_target = {reg_target[WIDTH-1:1], 1'b0};
  assign halted    = (state_q == ST_HALTED);

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    cnt_d   = taken_cnt;
    if (state_q == ST_HALTED) begin
      pc_d = pc;
    end else if (stall) begin
      pc_d = pc;
    end else if (halt) begin
      state_d = ST_HALTED;
    end else if (br_reg && taken) begin
      pc_d = br_target;
      if (taken_cnt != '1) cnt_d = taken_cnt + CNT_W'(1);
    end else if (br_en && taken) begin
      pc_d = b_target;
      if (taken_cnt != '1) cnt_d = taken_cnt + CNT_W'(1);
    end else begin
      pc_d = pc_plus2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc        <= RESET_PC;
      taken_cnt <= '0;
    end else begin
      state_q   <= state_d;
      pc        <= pc_d;
      taken_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_control.sv
module tb_branch_control;

  logic        clk;
  logic        rst_n;
  logic [2:0]  flags;
  logic        br_en;
  logic        br_reg;
  logic [2:0]  cond;
  logic [8:0]  imm;
  logic [15:0] reg_target;
  logic        halt;
  logic        stall;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        taken;
  logic        halted;
  logic [15:0] taken_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  logic [15:0] exp_pc;
  logic [15:0] exp_cnt;
  logic        exp_t;
  logic        z, v, n;

  branch_control #(
    .WIDTH    (16),
    .IMM_W    (9),
    .RESET_PC (16'h0000),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flags      (flags),
    .br_en      (br_en),
    .br_reg     (br_reg),
    .cond       (cond),
    .imm        (imm),
    .reg_target (reg_target),
    .halt       (halt),
    .stall      (stall),
    .pc         (pc),
    .pc_plus2   (pc_plus2),
    .taken      (taken),
    .halted     (halted),
    .taken_cnt  (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_en = 1'b0; br_reg = 1'b0; halt = 1'b0; stall = 1'b0;
    cond = 3'b000; flags = 3'b000; imm = '0; reg_target = '0;
  endtask

  // Committed BR jump used to place the PC at a chosen address.
  task automatic jump_to(input logic [15:0] tgt);
    idle_inputs();
    br_reg = 1'b1; cond = 3'b111; reg_target = tgt;
    step();
    exp_pc  = {tgt[15:1], 1'b0};
    exp_cnt = exp_cnt + 16'd1;
    check("jump_pc", pc, exp_pc);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n   = 1'b0;
    exp_cnt = 16'd0;
    #12;
    check("rst_pc", pc, 16'h0000);
    check("rst_halted", halted, 1'b0);
    check("rst_cnt", taken_cnt, 16'h0000);
    rst_n = 1'b1;

    // Sequential fetch.
    step(); check("seq_pc1", pc, 16'h0002);
    step(); check("seq_pc2", pc, 16'h0004);
    step(); check("seq_pc3", pc, 16'h0006);
    check("seq_halted", halted, 1'b0);
    check("seq_cnt", taken_cnt, 16'h0000);

    // PC-relative branch, backwards by 4 halfwords.
    jump_to(16'h0010);
    br_en = 1'b1; cond = 3'b001; flags = 3'b001; imm = 9'h1FC;
    #1;
    check("b_taken", taken, 1'b1);
    check("b_pc_plus2", pc_plus2, 16'h0012);
    step();
    exp_cnt = exp_cnt + 16'd1;
    check("b_pc", pc, 16'h000A);
    check("b_cnt", taken_cnt, exp_cnt);

    jump_to(16'h0010);
    br_en = 1'b1; cond = 3'b001; flags = 3'b000; imm = 9'h1FC;
    #1;
    check("b_nt_taken", taken, 1'b0);
    step();
    check("b_nt_pc", pc, 16'h0012);
    check("b_nt_cnt", taken_cnt, exp_cnt);
    exp_pc = 16'h0012;

    // Full condition table through BR; odd target checks bit0 clearing.
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        idle_inputs();
        br_reg = 1'b1; reg_target = 16'h1235;
        cond = 3'(c); flags = 3'(f);
        z = flags[0]; v = flags[1]; n = flags[2];
        case (c)
          0: exp_t = !z;
          1: exp_t = z;
          2: exp_t = !z && !n;
          3: exp_t = n;
          4: exp_t = !n || z;
          5: exp_t = n || z;
          6: exp_t = v;
          default: exp_t = 1'b1;
        endcase
        #1;
        check($sformatf("sweep_taken_c%0d_f%0d", c, f), taken, exp_t);
        step();
        if (exp_t) begin
          exp_pc  = 16'h1234;
          exp_cnt = exp_cnt + 16'd1;
        end else begin
          exp_pc = exp_pc + 16'd2;
        end
        check($sformatf("sweep_pc_c%0d_f%0d", c, f), pc, exp_pc);
      end
    end
    check("sweep_cnt", taken_cnt, exp_cnt);

    // Halt beats a simultaneous taken branch; HALTED absorbs everything.
    jump_to(16'h0040);
    halt = 1'b1; br_en = 1'b1; cond = 3'b111; imm = 9'h010;
    #1;
    check("halt_pre_halted", halted, 1'b0);
    step();
    check("halt_pc", pc, 16'h0040);
    check("halt_halted", halted, 1'b1);
    check("halt_cnt", taken_cnt, exp_cnt);
    halt = 1'b0;
    check("halt_taken", taken, 1'b0);
    step(); check("halt_pc2", pc, 16'h0040);
    stall = 1'b1; br_reg = 1'b1; reg_target = 16'h0100;
    step(); check("halt_pc3", pc, 16'h0040);
    stall = 1'b0;
    step(); check("halt_pc4", pc, 16'h0040);
    check("halt_halted2", halted, 1'b1);
    check("halt_cnt2", taken_cnt, exp_cnt);
    #2;
    rst_n = 1'b0;
    #1;
    check("midhalt_rst_pc", pc, 16'h0000);
    check("midhalt_rst_halted", halted, 1'b0);
    check("midhalt_rst_cnt", taken_cnt, 16'h0000);
    exp_cnt = 16'd0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(); check("post_rst_pc", pc, 16'h0002);

    // A halt under stall is dropped; it commits once the stall clears.
    jump_to(16'h0020);
    stall = 1'b1; halt = 1'b1;
    step();
    check("stall_halt_pc", pc, 16'h0020);
    check("stall_halt_halted", halted, 1'b0);
    stall = 1'b0;
    step();
    check("halt_after_stall_pc", pc, 16'h0020);
    check("halt_after_stall_halted", halted, 1'b1);

    // Stall alone holds pc and counter.
    rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    jump_to(16'h0030);
    stall = 1'b1; br_reg = 1'b1; cond = 3'b111; reg_target = 16'h0500;
    step();
    check("stall_pc", pc, 16'h0030);
    check("stall_cnt", taken_cnt, exp_cnt);
    idle_inputs();

    // PC wrap-around; odd BR target lands on FFFE.
    jump_to(16'hFFFF);
    check("wrap_pre_pc", pc, 16'hFFFE);
    check("wrap_plus2", pc_plus2, 16'h0000);
    step();
    check("wrap_pc", pc, 16'h0000);

    // Counter saturation with a branch-to-self loop.
    br_en = 1'b1; cond = 3'b111; imm = 9'h1FF;
    while (exp_cnt != 16'hFFFF) begin
      step();
      exp_cnt = exp_cnt + 16'd1;
    end
    check("sat_cnt", taken_cnt, 16'hFFFF);
    check("sat_loop_pc", pc, 16'h0000);
    step(); step(); step();
    check("sat_hold_cnt", taken_cnt, 16'hFFFF);
    check("sat_hold_pc", pc, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
